// File: rtl/pool_layer_param.sv
// pool_layer_param: KxK / stride-S max or average pooling of a CH x IN x IN map held in BRAM.
// Optional: define POOL_RELU_EN to clamp negative results to zero before the write.
module pool_layer_param #(
   parameter int DW       = 16,
   parameter int AW       = 13,
   parameter int CH       = 6,
   parameter int IN       = 28,
   parameter int K        = 2,
   parameter int S        = 2,
   parameter int RD_LAT   = 2,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 4704
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   output logic          busy,
   output logic          done,
   output logic          bram_ena,
   output logic          bram_wea,
   output logic [AW-1:0] bram_addra,
   output logic [DW-1:0] bram_dina,
   input  logic [DW-1:0] bram_douta
);

   localparam int OUT  = (IN - K) / S + 1;
   localparam int LK   = $clog2(K);
   localparam int ACCW = DW + 2 * LK;
   localparam int DCW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   localparam logic [15:0]    CH_L  = 16'(CH - 1);
   localparam logic [15:0]    OUT_L = 16'(OUT - 1);
   localparam logic [3:0]     K_L   = 4'(K - 1);
   localparam logic [DCW-1:0] D_L   = DCW'(RD_LAT - 1);

   typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

   state_t                  state;
   logic                    mode_r;
   logic [15:0]             ch, row, col;
   logic [15:0]             n_ch, n_row, n_col;
   logic [3:0]              wi, wj, n_i, n_j;
   logic                    last_tap, last_win;
   logic [DCW-1:0]          dcnt;
   logic [RD_LAT-1:0]       vld;
   logic                    first;
   logic signed [DW-1:0]    din_s;
   logic signed [ACCW-1:0]  samp, acc, acc_nxt, shr;
   logic [DW-1:0]           res_raw, res;

   function automatic logic [AW-1:0] src_addr(input logic [15:0] c, r, q,
                                               input logic [3:0] i, j);
      int a;
      a = SRC_BASE + int'(c) * IN * IN + (int'(r) * S + int'(i)) * IN
          + int'(q) * S + int'(j);
      return AW'(a);
   endfunction

   function automatic logic [AW-1:0] dst_addr(input logic [15:0] c, r, q);
      int a;
      a = DST_BASE + int'(c) * OUT * OUT + int'(r) * OUT + int'(q);
      return AW'(a);
   endfunction

   assign din_s = bram_douta;

   // Next tap inside the window (row-major) and next window position.
   always_comb begin
      n_i      = wi;
      n_j      = wj + 4'd1;
      if (wj == K_L) begin
         n_j = '0;
         n_i = wi + 4'd1;
      end
      last_tap = (wi == K_L) && (wj == K_L);
      n_col    = col + 16'd1;
      n_row    = row;
      n_ch     = ch;
      if (col == OUT_L) begin
         n_col = '0;
         n_row = row + 16'd1;
         if (row == OUT_L) begin
            n_row = '0;
            n_ch  = ch + 16'd1;
         end
      end
      last_win = (ch == CH_L) && (row == OUT_L) && (col == OUT_L);
   end

   // Fold the sample arriving this cycle into the window accumulator.
   always_comb begin
      samp    = ACCW'(din_s);
      acc_nxt = acc;
      if (vld[RD_LAT-1]) begin
         if (first)
            acc_nxt = samp;
         else if (mode_r)
            acc_nxt = acc + samp;
         else if (samp > acc)
            acc_nxt = samp;
      end
      shr     = acc_nxt >>> (2 * LK);
      res_raw = mode_r ? shr[DW-1:0] : acc_nxt[DW-1:0];
`ifdef POOL_RELU_EN
      res     = res_raw[DW-1] ? '0 : res_raw;
`else
      res     = res_raw;
`endif
   end

   // Control FSM, read-valid delay line and registered BRAM port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mode_r     <= 1'b0;
         ch         <= '0;
         row        <= '0;
         col        <= '0;
         wi         <= '0;
         wj         <= '0;
         dcnt       <= '0;
         vld        <= '0;
         first      <= 1'b0;
         acc        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bram_ena   <= 1'b0;
         bram_wea   <= 1'b0;
         bram_addra <= '0;
         bram_dina  <= '0;
      end else begin
         done <= 1'b0;
         vld  <= RD_LAT'({vld, bram_ena & ~bram_wea});
         acc  <= acc_nxt;
         if (vld[RD_LAT-1])
            first <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  mode_r     <= mode;
                  ch         <= '0;
                  row        <= '0;
                  col        <= '0;
                  wi         <= '0;
                  wj         <= '0;
                  first      <= 1'b1;
                  busy       <= 1'b1;
                  bram_ena   <= 1'b1;
                  bram_wea   <= 1'b0;
                  bram_addra <= src_addr('0, '0, '0, '0, '0);
                  state      <= READ;
               end
            end
            READ: begin
               if (last_tap) begin
                  wi       <= '0;
                  wj       <= '0;
                  dcnt     <= '0;
                  bram_ena <= 1'b0;
                  state    <= DRAIN;
               end else begin
                  wi         <= n_i;
                  wj         <= n_j;
                  bram_addra <= src_addr(ch, row, col, n_i, n_j);
               end
            end
            DRAIN: begin
               if (dcnt == D_L) begin
                  bram_ena   <= 1'b1;
                  bram_wea   <= 1'b1;
                  bram_addra <= dst_addr(ch, row, col);
                  bram_dina  <= res;
                  state      <= WRITE;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            WRITE: begin
               bram_wea <= 1'b0;
               ch       <= last_win ? '0 : n_ch;
               row      <= n_row;
               col      <= n_col;
               if (last_win) begin
                  bram_ena <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  bram_ena   <= 1'b1;
                  bram_addra <= src_addr(n_ch, n_row, n_col, '0, '0);
                  first      <= 1'b1;
                  state      <= READ;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pool_layer_param.sv
// tb_pool_layer_param: directed checks of the pooling engine, default build plus a 3x3 variant.
// Expected values are hand-derived from the BRAM contents each test preloads.
module tb_pool_layer_param;

   localparam int NW  = 1176;
   localparam int DST = 4704;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, start = 1'b0, mode = 1'b0, start2 = 1'b0;
   logic        busy, done, ena, wea;
   logic [12:0] addra;
   logic [15:0] dina, douta;
   logic        busy2, done2, ena2, wea2;
   logic [12:0] addra2;
   logic [15:0] dina2, douta2;
   int          tests = 0, fails = 0;

   pool_layer_param dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .busy(busy), .done(done), .bram_ena(ena), .bram_wea(wea),
      .bram_addra(addra), .bram_dina(dina), .bram_douta(douta)
   );

   pool_layer_param #(.CH(2), .IN(5), .K(3), .S(2), .RD_LAT(1), .DST_BASE(64)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mode(1'b0),
      .busy(busy2), .done(done2), .bram_ena(ena2), .bram_wea(wea2),
      .bram_addra(addra2), .bram_dina(dina2), .bram_douta(douta2)
   );

   logic [15:0] mem  [0:8191];
   logic [15:0] mem2 [0:127];
   logic [15:0] rp0, rp1, rq;
   assign douta  = rp1;
   assign douta2 = rq;

   // BRAM models: latency 2 for the default DUT, latency 1 for the variant.
   always @(posedge clk) begin
      if (ena && wea) mem[addra] <= dina;
      if (ena && !wea) rp0 <= mem[addra];
      rp1 <= rp0;
      if (ena2 && wea2) mem2[addra2[6:0]] <= dina2;
      if (ena2 && !wea2) rq <= mem2[addra2[6:0]];
   end

   int          wr_cnt = 0, done_cnt = 0, wr_cnt2 = 0;
   logic [12:0] last_wa;
   logic [15:0] last_wd;
   logic [12:0] rdq[$];
   logic [12:0] rdq2[$];

   // Bus monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (ena && wea) begin
         wr_cnt++;
         last_wa = addra;
         last_wd = dina;
      end
      if (ena && !wea) rdq.push_back(addra);
      if (done) done_cnt++;
      if (ena2 && wea2) wr_cnt2++;
      if (ena2 && !wea2) rdq2.push_back(addra2);
   end

   task automatic fill_src();
      for (int a = 0; a < DST; a++) mem[a] = 16'(a);
   endtask

   task automatic clear_dst();
      for (int a = DST; a < DST + NW; a++) mem[a] = 16'hAAAA;
   endtask

   function automatic int map_errs();
      int e = 0;
      for (int c = 0; c < 6; c++)
         for (int r = 0; r < 14; r++)
            for (int q = 0; q < 14; q++)
               if (mem[DST + c * 196 + r * 14 + q] !== 16'(c * 784 + (2 * r + 1) * 28 + 2 * q + 1))
                  e++;
      return e;
   endfunction

   task automatic run_main(input logic m, output int cyc);
      int n;
      @(negedge clk);
      mode  = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n     = 1;
      while (!done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      cyc = done ? n : -1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", done); end
      tests++; if ({ena, wea} !== 2'b00) begin fails++; $display("FAIL rst_ena_wea got %b want 00", {ena, wea}); end
      tests++; if (addra !== 13'd0) begin fails++; $display("FAIL rst_addr got %0d want 0", addra); end
      tests++; if (dina !== 16'd0) begin fails++; $display("FAIL rst_dina got %0d want 0", dina); end
      tests++; if ({busy2, done2, ena2, wea2} !== 4'b0) begin fails++; $display("FAIL rst_variant got %b want 0000", {busy2, done2, ena2, wea2}); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if ({busy, ena} !== 2'b00) begin fails++; $display("FAIL idle_quiet got %b want 00", {busy, ena}); end
   endtask

   task automatic test_max_map();
      int cyc, b, rb;
      logic [12:0] er [4];
      er = '{13'd0, 13'd1, 13'd28, 13'd29};
      fill_src();
      clear_dst();
      b  = wr_cnt;
      rb = rdq.size();
      run_main(1'b0, cyc);
      tests++; if (cyc !== 8233) begin fails++; $display("FAIL max_cycles got %0d want 8233", cyc); end
      tests++; if (rdq.size() - rb !== 4704) begin fails++; $display("FAIL max_reads got %0d want 4704", rdq.size() - rb); end
      for (int i = 0; i < 4; i++) begin
         tests++; if (rdq[rb + i] !== er[i]) begin fails++; $display("FAIL first_read%0d got %0d want %0d", i, rdq[rb + i], er[i]); end
      end
      tests++; if (mem[DST] !== 16'd29) begin fails++; $display("FAIL first_write got %0d want 29", mem[DST]); end
      tests++; if (wr_cnt - b !== NW) begin fails++; $display("FAIL max_writes got %0d want 1176", wr_cnt - b); end
      tests++; if (last_wa !== 13'd5879) begin fails++; $display("FAIL last_addr got %0d want 5879", last_wa); end
      tests++; if (last_wd !== 16'd4703) begin fails++; $display("FAIL last_data got %0d want 4703", last_wd); end
      tests++; if (map_errs() !== 0) begin fails++; $display("FAIL max_map got %0d bad want 0", map_errs()); end
      tests++; if ({ena, wea, busy} !== 3'b000) begin fails++; $display("FAIL post_done got %b want 000", {ena, wea, busy}); end
   endtask

   task automatic test_avg();
      int cyc;
      logic [15:0] e1;
`ifdef POOL_RELU_EN
      e1 = 16'h0000;
`else
      e1 = 16'hFFFE;
`endif
      mem[0] = 16'd4;     mem[1] = 16'd5;     mem[28] = 16'd6;     mem[29] = 16'hFFFD;
      mem[2] = 16'hFFFF;  mem[3] = 16'hFFFE;  mem[30] = 16'hFFFF;  mem[31] = 16'hFFFF;
      mem[4] = 16'h7FFF;  mem[5] = 16'h7FFF;  mem[32] = 16'h7FFF;  mem[33] = 16'h7FFF;
      clear_dst();
      run_main(1'b1, cyc);
      tests++; if (cyc !== 8233) begin fails++; $display("FAIL avg_cycles got %0d want 8233", cyc); end
      tests++; if (mem[DST] !== 16'd3) begin fails++; $display("FAIL avg_mixed got %h want 0003", mem[DST]); end
      tests++; if (mem[DST + 1] !== e1) begin fails++; $display("FAIL avg_neg got %h want %h", mem[DST + 1], e1); end
      tests++; if (mem[DST + 2] !== 16'h7FFF) begin fails++; $display("FAIL avg_sat got %h want 7fff", mem[DST + 2]); end
      tests++; if (mem[DST + 3] !== 16'd20) begin fails++; $display("FAIL avg_w3 got %0d want 20", mem[DST + 3]); end
      tests++; if (mem[DST + 13] !== 16'd40) begin fails++; $display("FAIL avg_w13 got %0d want 40", mem[DST + 13]); end
   endtask

   task automatic test_back_to_back();
      int n, d0, cyc, bad;
      logic        pb;
      logic [15:0] snap [NW];
      logic [15:0] e3, e1;
`ifdef POOL_RELU_EN
      e3 = 16'h0000;
      e1 = 16'h0000;
`else
      e3 = 16'hFFF9;
      e1 = 16'hFFFF;
`endif
      mem[6] = 16'hFFF9; mem[7] = 16'hFFF8; mem[34] = 16'hFFF7; mem[35] = 16'hFFF6;
      clear_dst();
      d0 = done_cnt;
      @(negedge clk);
      mode  = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n     = 1;
      pb    = 1'b0;
      while (!done && n < 20000) begin
         start = (n == 50);
         pb    = busy;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      tests++; if (n !== 8233) begin fails++; $display("FAIL hs_cycles got %0d want 8233", n); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_in_done got %b want 0", busy); end
      tests++; if (pb !== 1'b1) begin fails++; $display("FAIL busy_before_done got %b want 1", pb); end
      repeat (20) @(negedge clk);
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL done_pulses got %0d want 1", done_cnt - d0); end
      tests++; if (mem[DST] !== 16'd6) begin fails++; $display("FAIL max_w0 got %0d want 6", mem[DST]); end
      tests++; if (mem[DST + 1] !== e1) begin fails++; $display("FAIL max_w1 got %h want %h", mem[DST + 1], e1); end
      tests++; if (mem[DST + 3] !== e3) begin fails++; $display("FAIL relu_w3 got %h want %h", mem[DST + 3], e3); end
      for (int i = 0; i < NW; i++) snap[i] = mem[DST + i];
      clear_dst();
      run_main(1'b0, cyc);
      bad = 0;
      for (int i = 0; i < NW; i++) if (mem[DST + i] !== snap[i]) bad++;
      tests++; if (cyc !== 8233) begin fails++; $display("FAIL rerun_cycles got %0d want 8233", cyc); end
      tests++; if (bad !== 0) begin fails++; $display("FAIL rerun_map got %0d diffs want 0", bad); end
   endtask

   task automatic test_reset_mid();
      int n, b, d0, cyc;
      fill_src();
      clear_dst();
      b  = wr_cnt;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n     = 0;
      while ((wr_cnt - b) < 100 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_mid got %b want 1", busy); end
      rst = 1'b1;
      @(negedge clk);
      tests++; if ({ena, wea, busy, done} !== 4'b0) begin fails++; $display("FAIL abort got %b want 0000", {ena, wea, busy, done}); end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      tests++; if (done_cnt !== d0) begin fails++; $display("FAIL abort_done got %0d want %0d", done_cnt, d0); end
      tests++; if (mem[DST + 100] !== 16'hAAAA) begin fails++; $display("FAIL abort_w100 got %h want aaaa", mem[DST + 100]); end
      b = wr_cnt;
      run_main(1'b0, cyc);
      tests++; if (cyc !== 8233) begin fails++; $display("FAIL restart_cycles got %0d want 8233", cyc); end
      tests++; if (wr_cnt - b !== NW) begin fails++; $display("FAIL restart_writes got %0d want 1176", wr_cnt - b); end
      tests++; if (map_errs() !== 0) begin fails++; $display("FAIL restart_map got %0d bad want 0", map_errs()); end
   endtask

   task automatic test_variant();
      int n, b, rb;
      logic [12:0] er [9];
      er = '{13'd37, 13'd38, 13'd39, 13'd42, 13'd43, 13'd44, 13'd47, 13'd48, 13'd49};
      for (int a = 0; a < 128; a++) mem2[a] = 16'(a);
      mem2[43] = 16'd500;
      b  = wr_cnt2;
      rb = rdq2.size();
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n      = 1;
      while (!done2 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      tests++; if (n !== 89) begin fails++; $display("FAIL var_cycles got %0d want 89", n); end
      @(negedge clk);
      tests++; if (wr_cnt2 - b !== 8) begin fails++; $display("FAIL var_writes got %0d want 8", wr_cnt2 - b); end
      tests++; if (rdq2.size() - rb !== 72) begin fails++; $display("FAIL var_reads got %0d want 72", rdq2.size() - rb); end
      for (int i = 0; i < 9; i++) begin
         tests++; if (rdq2[rb + 63 + i] !== er[i]) begin fails++; $display("FAIL var_read%0d got %0d want %0d", i, rdq2[rb + 63 + i], er[i]); end
      end
      tests++; if (mem2[64] !== 16'd12) begin fails++; $display("FAIL var_c0w0 got %0d want 12", mem2[64]); end
      tests++; if (mem2[67] !== 16'd24) begin fails++; $display("FAIL var_c0w3 got %0d want 24", mem2[67]); end
      tests++; if (mem2[69] !== 16'd39) begin fails++; $display("FAIL var_c1w1 got %0d want 39", mem2[69]); end
      tests++; if (mem2[70] !== 16'd47) begin fails++; $display("FAIL var_c1w2 got %0d want 47", mem2[70]); end
      tests++; if (mem2[71] !== 16'd500) begin fails++; $display("FAIL var_c1w3 got %0d want 500", mem2[71]); end
   endtask

   initial begin
      test_reset();
      test_max_map();
      test_avg();
      test_back_to_back();
      test_reset_mid();
      test_variant();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pool_layer_param.md
Name: pool_layer_param

Overview:
- Parametrised pooling engine, successor to the fixed 6x28x28, 2x2 max-pool stage.
- Reads a CH x IN x IN feature map from the shared result BRAM (single port), reduces each KxK window at stride S by max or average, and writes a CH x OUT x OUT map back to the same BRAM.
- Sits between a conv layer and the next conv layer. The top-level sequencer starts it with a start/done handshake.

Parameters:
- DW, 16, data width; signed two's-complement fixed point.
- AW, 13, BRAM address width.
- CH, 6, number of channels.
- IN, 28, input map side length.
- K, 2, window side. Max mode: any value 1..8. Avg mode: 1, 2, 4 or 8 only.
- S, 2, stride. OUT = (IN-K)/S + 1, integer division.
- RD_LAT, 2, BRAM read latency in cycles (1..4).
- SRC_BASE, 0, input map base address.
- DST_BASE, 4704, output map base address.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; starts the layer when idle
- mode  in  1  0 = max, 1 = average; sampled on accepted start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse after the last write
- bram_ena  out  1  BRAM enable
- bram_wea  out  1  BRAM write enable
- bram_addra  out  AW  BRAM address
- bram_dina  out  DW  write data
- bram_douta  in  DW  read data, valid RD_LAT cycles after the address

Behaviour:
- Reset: all outputs 0; state IDLE; counters (ch, row, col, k index) 0. Reset mid-operation aborts immediately with no done pulse, and the next start runs a full layer.
- IDLE:
  - start=1 latches mode, clears counters, sets busy, goes to READ.
  - start while busy is ignored.
- READ, K*K cycles:
  - Each cycle: ena=1, wea=0, addr = SRC_BASE + ch*IN*IN + (row*S+i)*IN + col*S + j, with i,j in row-major window order.
  - One address per cycle, pipelined.
- DRAIN, RD_LAT cycles: ena=0. Read data is captured RD_LAT cycles after each address.
- Reduction, done with a delay line of RD_LAT valid flags:
  - Max mode: first captured sample initialises the accumulator; later samples replace it if signed-greater.
  - Avg mode: accumulator is DW+2*log2(K) bits wide and sums sign-extended samples.
- WRITE, 1 cycle:
  - ena=1, wea=1, addr = DST_BASE + ch*OUT*OUT + row*OUT + col.
  - dina = max result, or sum >>> 2*log2(K) in avg mode (arithmetic shift, rounds toward -inf; truncated to DW, cannot overflow).
  - Next cycle: ena=0 and wea=0.
- Advance after WRITE:
  - col wraps at OUT and increments row; row wraps at OUT and increments ch.
  - If the last window of the last channel was just written, go to DONE; else go to READ.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Timing:
  - Each window takes K*K + RD_LAT + 1 cycles.
  - First address is issued the cycle after start.
  - Total start-to-done = CH*OUT*OUT*(K*K+RD_LAT+1) + 1 cycles.
- No BRAM access outside READ and WRITE. ena is never asserted while wea is asserted in a read slot.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: the WRITE value is clamped to 0 when negative (fused ReLU), in both modes.
- Undefined: the value is written unmodified.

Test Plan:
1. Defaults, mode=0, mem[a]=a:
   - First window reads 0,1,28,29 and writes 29 at 4704.
   - Last write at 5879, value 4703.
   - 1176 writes total; done exactly 1176*7+1 cycles after start.
2. mode=1, K=2:
   - Window 4,5,6,-3 writes 3.
   - Window -1,-2,-1,-1 writes -2 (0xFFFE).
   - Window 32767 x4 writes 32767 (no overflow).
3. All-negative window, max=-7:
   - With POOL_RELU_EN: writes 0.
   - Without: writes 0xFFF9.
4. Handshake:
   - Start pulsed again mid-run: no effect, single done pulse.
   - Busy falls in the done cycle.
   - Second start after done reruns with identical results.
5. Reset mid-run:
   - Assert rst during window 100: ena=wea=busy=0 next cycle, no done.
   - Restart produces a full correct map.
6. Variant CH=2, IN=5, K=3, S=2, RD_LAT=1, max mode:
   - OUT=2, 8 writes.
   - Window (1,1) of ch1 reads 25+{12,13,14,17,18,19,22,23,24}.
   - Correct max written at DST_BASE+7.
